char_buf_scroll_clear_engine: RTL and testbench

Hardware assist for the 2048×32 dual-port character-buffer SRAM in the VGA subsystem. It clears the text screen, or scrolls it up one row and blanks the bottom row, through the SRAM's second port, leaving the first port free for the processor. Software controls it through a small Avalon-MM slave: start a command, poll busy or take an interrupt. The characters are packed 4 per 32-bit word, and rows are stored contiguously from word 0.

---
 rtl/char_buf_scroll_clear_engine.sv | 167 ++++++++++++++++
 tb/tb_char_buf_scroll_clear_engine.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_buf_scroll_clear_engine.sv
// Clear/scroll assist for the dual-port character-buffer SRAM, driven through port 2.
// Software starts a command over a two-register Avalon-MM slave and polls busy/done or takes irq.
module char_buf_scroll_clear_engine #(
  parameter int COLS_WORDS = 20,
  parameter int ROWS       = 60,
  parameter int ADDR_W     = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              avs_address,
  input  logic              avs_write,
  input  logic              avs_read,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              irq,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata
);

  // state   | meaning
  // IDLE    | port 2 released, waiting for a start
  // CLR_WR  | writing fill_word to word i over the whole screen
  // SCR_RD  | reading word i+COLS_WORDS (one row below)
  // SCR_WR  | writing the word just read to word i
  // FILL_WR | blanking the bottom row with fill_word
  typedef enum logic [2:0] {IDLE, CLR_WR, SCR_RD, SCR_WR, FILL_WR} state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(ROWS * COLS_WORDS - 1);
  localparam logic [ADDR_W-1:0] LAST_SCR  = ADDR_W'((ROWS - 1) * COLS_WORDS - 1);
  localparam logic [ADDR_W-1:0] ROW_OFS   = ADDR_W'(COLS_WORDS);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0]       fill_word_q, fill_word_d;
  logic [7:0]        fill_char_q, fill_char_d;
  logic              irq_en_q, irq_en_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_fill_q, mem_fill_d;

  logic ctrl_wr, stat_wr, abort, done_set, busy;
  logic unused_wdata;

  assign ctrl_wr      = avs_write & ~avs_address;
  assign stat_wr      = avs_write &  avs_address;
  assign abort        = ctrl_wr & avs_writedata[2];
  assign busy         = (state_q != IDLE);
  assign unused_wdata = ^{avs_writedata[31:17], avs_writedata[7:3]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_word_d = fill_word_q;
    fill_char_d = fill_char_q;
    irq_en_d    = irq_en_q;
    done_d      = done_q;
    done_set    = 1'b0;

    if (ctrl_wr) begin
      fill_char_d = avs_writedata[15:8];
      irq_en_d    = avs_writedata[16];
    end

    case (state_q)
      IDLE: begin
        if (ctrl_wr && !avs_writedata[2] && (avs_writedata[0] || avs_writedata[1])) begin
          cnt_d       = '0;
          fill_word_d = {4{avs_writedata[15:8]}};
          state_d     = avs_writedata[0] ? CLR_WR : SCR_RD;
        end
      end
      CLR_WR, FILL_WR: begin
        if (cnt_q == LAST_WORD) begin
          state_d  = IDLE;
          done_set = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      SCR_RD: state_d = SCR_WR;
      SCR_WR: begin
        cnt_d   = cnt_q + ONE;
        state_d = (cnt_q == LAST_SCR) ? FILL_WR : SCR_RD;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including a completion on the same edge.
    if (abort) begin
      state_d  = IDLE;
      done_set = 1'b0;
    end

    if (done_set) begin
      done_d = 1'b1;
    end else if (stat_wr && avs_writedata[1]) begin
      done_d = 1'b0;
    end

    // Port-2 controls are precomputed for the state being entered so they are registered.
    mem_cs_d   = (state_d != IDLE);
    mem_we_d   = (state_d == CLR_WR) || (state_d == SCR_WR) || (state_d == FILL_WR);
    mem_addr_d = '0;
    mem_fill_d = '0;
    case (state_d)
      CLR_WR, FILL_WR: begin
        mem_addr_d = cnt_d;
        mem_fill_d = fill_word_d;
      end
      SCR_WR:  mem_addr_d = cnt_d;
      SCR_RD:  mem_addr_d = cnt_d + ROW_OFS;
      default: mem_addr_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fill_word_q <= '0;
      fill_char_q <= '0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_fill_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_word_q <= fill_word_d;
      fill_char_q <= fill_char_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      mem_addr_q  <= mem_addr_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_fill_q  <= mem_fill_d;
    end
  end

  // Read data only becomes valid in SCR_WR, so the scroll data path is passed straight through.
  assign mem_writedata  = (state_q == SCR_WR) ? mem_readdata : mem_fill_q;
  assign mem_address    = mem_addr_q;
  assign mem_chipselect = mem_cs_q;
  assign mem_write      = mem_we_q;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign irq            = done_q & irq_en_q;

  always_comb begin
    avs_readdata = '0;
    if (avs_read) begin
      if (avs_address) avs_readdata = {30'b0, done_q, busy};
      else             avs_readdata = {15'b0, irq_en_q, fill_char_q, 8'b0};
    end
  end

endmodule

// File: tb/tb_char_buf_scroll_clear_engine.sv
// Bench for char_buf_scroll_clear_engine: SRAM model, screen-level reference model,
// per-cycle port-2 compare and directed plus randomized command sequences.
module tb_char_buf_scroll_clear_engine;
  localparam int COLS = 20;
  localparam int NW   = 1200;
  localparam int SW   = 1180;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        preload = 1'b1;
  logic        avs_address = 1'b0;
  logic        avs_write = 1'b0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        irq;
  logic [10:0] mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  char_buf_scroll_clear_engine #(.COLS_WORDS(20), .ROWS(60), .ADDR_W(11)) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_address(avs_address), .avs_write(avs_write), .avs_read(avs_read),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // SRAM port 2: synchronous write, read data one cycle after the address
  logic [31:0] sram [0:2047];
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 2048; k++) sram[k] <= 32'hA000_0000 + 32'(k);
    end else if (mem_chipselect) begin
      if (mem_write) sram[mem_address] <= mem_writedata;
      mem_readdata <= sram[mem_address];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: screen contents at command acceptance, busy as a countdown
  logic [31:0] ref_mem [0:2047];
  logic [31:0] pre     [0:2047];
  logic        ref_valid = 1'b0;
  logic        m_pre_valid = 1'b0;
  int          m_left = 0;
  int          m_total = 0;
  logic        m_kind = 1'b0;
  logic        m_done = 1'b0;
  logic        m_irq_en = 1'b0;
  logic [7:0]  m_fill = '0;
  logic [31:0] m_fw = '0;

  logic mw_ctrl, mw_stat, mw_abort, mw_start;
  logic [31:0] mw_fw;
  assign mw_ctrl  = avs_write && !avs_address;
  assign mw_stat  = avs_write && avs_address;
  assign mw_abort = mw_ctrl && avs_writedata[2];
  assign mw_start = mw_ctrl && (avs_writedata[0] || avs_writedata[1]);
  assign mw_fw    = {4{avs_writedata[15:8]}};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if (preload) begin
        for (int k = 0; k < 2048; k++) ref_mem[k] <= 32'hA000_0000 + 32'(k);
        ref_valid <= 1'b1;
      end else if (m_left != 0) begin
        ref_valid <= 1'b0;
      end
      m_left <= 0; m_total <= 0; m_kind <= 1'b0; m_done <= 1'b0;
      m_irq_en <= 1'b0; m_fill <= '0; m_fw <= '0;
    end else begin
      if (mw_ctrl) begin
        m_irq_en <= avs_writedata[16];
        m_fill   <= avs_writedata[15:8];
      end
      if (mw_abort) begin
        if (m_left != 0) ref_valid <= 1'b0;
        m_left <= 0;
      end else if (m_left == 0 && mw_start) begin
        m_kind      <= !avs_writedata[0];
        m_total     <= avs_writedata[0] ? NW : 2 * SW + COLS;
        m_left      <= avs_writedata[0] ? NW : 2 * SW + COLS;
        m_fw        <= mw_fw;
        m_pre_valid <= ref_valid;
        if (avs_writedata[0]) ref_valid <= 1'b1;
        for (int k = 0; k < NW; k++) begin
          pre[k] <= ref_mem[k];
          if (avs_writedata[0] || k >= SW) ref_mem[k] <= mw_fw;
          else                             ref_mem[k] <= ref_mem[k + COLS];
        end
      end else if (m_left != 0) begin
        m_left <= m_left - 1;
      end
      if (m_left == 1 && !mw_abort) m_done <= 1'b1;
      else if (mw_stat && avs_writedata[1]) m_done <= 1'b0;
    end
  end

  typedef struct packed {
    logic        we;
    logic        dchk;
    logic [10:0] addr;
    logic [31:0] data;
  } mexp_t;

  // Expected port-2 activity in busy cycle e of the current command
  function automatic mexp_t mem_exp(input int e);
    mexp_t r;
    r = '0;
    if (!m_kind) begin
      r.we = 1'b1; r.dchk = 1'b1; r.addr = 11'(e); r.data = m_fw;
    end else if (e < 2 * SW) begin
      if (e % 2 == 0) begin
        r.addr = 11'(e / 2 + COLS);
      end else begin
        r.we = 1'b1; r.dchk = m_pre_valid; r.addr = 11'((e - 1) / 2);
        r.data = pre[(e - 1) / 2 + COLS];
      end
    end else begin
      r.we = 1'b1; r.dchk = 1'b1; r.addr = 11'(SW + e - 2 * SW); r.data = m_fw;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_cs", {31'b0, mem_chipselect}, 32'd0);
      chk("rst_we", {31'b0, mem_write}, 32'd0);
      chk("rst_addr", {21'b0, mem_address}, 32'd0);
      chk("rst_wdata", mem_writedata, 32'd0);
      chk("rst_irq", {31'b0, irq}, 32'd0);
    end else begin
      chk("irq", {31'b0, irq}, {31'b0, m_done & m_irq_en});
      chk("cs", {31'b0, mem_chipselect}, {31'b0, m_left != 0});
      if (m_left == 0) begin
        chk("we_idle", {31'b0, mem_write}, 32'd0);
      end else begin
        chk("we", {31'b0, mem_write}, {31'b0, mem_exp(m_total - m_left).we});
        chk("addr", {21'b0, mem_address}, {21'b0, mem_exp(m_total - m_left).addr});
        if (mem_exp(m_total - m_left).we && mem_exp(m_total - m_left).dchk)
          chk("wdata", mem_writedata, mem_exp(m_total - m_left).data);
      end
    end
    if (!avs_read) chk("rdata_idle", avs_readdata, 32'd0);
  end

  logic irq_prev = 1'b0;
  int   irq_rises = 0;
  always @(negedge clk) begin
    irq_prev <= irq;
    if (irq && !irq_prev) irq_rises <= irq_rises + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic rd_exp(input logic a, input logic [31:0] e, input string nm);
    avs_address = a; avs_read = 1'b1;
    #1;
    chk(nm, avs_readdata, e);
    avs_read = 1'b0;
  endtask

  task automatic rd_model(input logic a, input string nm);
    if (a) rd_exp(a, {30'b0, m_done, m_left != 0}, nm);
    else   rd_exp(a, {15'b0, m_irq_en, m_fill, 8'b0}, nm);
  endtask

  task automatic wait_idle(output int c);
    logic b;
    c = 0;
    forever begin
      avs_address = 1'b1; avs_read = 1'b1;
      #1;
      b = avs_readdata[0];
      avs_read = 1'b0;
      if (!b) break;
      if (c >= 5000) begin chk("busy_timeout", 32'd1, 32'd0); break; end
      c++;
      tick(1);
    end
  endtask

  task automatic mem_check(input string nm);
    int bad;
    bad = 0;
    for (int k = 0; k < 2048; k++) if (sram[k] !== ref_mem[k]) bad++;
    chk(nm, 32'(bad), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c, r0, ab_at, rsel;
    logic ie, kind, b1, do_ab;
    logic [7:0] fill;

    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;
    rd_exp(1'b0, 32'd0, "rst_ctrl_rd");
    rd_exp(1'b1, 32'd0, "rst_stat_rd");
    tick(1);
    reset_n = 1'b1;
    tick(2);

    // scroll, fill 0x00, irq_en=1
    wr(1'b0, 32'h0001_0002);
    wait_idle(c);
    chk("scroll_cycles", 32'(c), 32'd2380);
    chk("scroll_irq", {31'b0, irq}, 32'd1);
    chk("scr_w0", sram[0], 32'hA000_0014);
    chk("scr_w1179", sram[1179], 32'hA000_04AF);
    chk("scr_w1180", sram[1180], 32'h0000_0000);
    chk("scr_w1199", sram[1199], 32'h0000_0000);
    chk("scr_w1200", sram[1200], 32'hA000_04B0);
    mem_check("scroll_mem");

    wr(1'b0, 32'h0000_0000);
    chk("irq_en_drop", {31'b0, irq}, 32'd0);
    rd_exp(1'b1, 32'd2, "done_kept");
    wr(1'b0, 32'h0001_0000);
    chk("irq_en_raise", {31'b0, irq}, 32'd1);
    rd_exp(1'b0, 32'h0001_0000, "ctrl_rd");
    wr(1'b1, 32'h0000_0002);
    chk("done_clr_irq", {31'b0, irq}, 32'd0);
    rd_exp(1'b1, 32'd0, "done_clr_stat");

    // clear 0x20, done-clear coinciding with completion
    wr(1'b0, 32'h0000_2001);
    tick(1199);
    rd_exp(1'b1, 32'd1, "clr_last_busy");
    wr(1'b1, 32'h0000_0002);
    rd_exp(1'b1, 32'd2, "done_set_wins");
    chk("clr_irq_off", {31'b0, irq}, 32'd0);
    chk("clr_w0", sram[0], 32'h2020_2020);
    chk("clr_w1199", sram[1199], 32'h2020_2020);
    chk("clr_w1200", sram[1200], 32'hA000_04B0);
    mem_check("clear_mem");

    // start while busy is ignored, exactly one done
    wr(1'b1, 32'h0000_0002);
    r0 = irq_rises;
    wr(1'b0, 32'h0001_5501);
    c = 0;
    forever begin
      avs_address = 1'b1; avs_read = 1'b1;
      #1;
      avs_read = 1'b0;
      if (!avs_readdata[0]) break;
      if (c >= 5000) begin chk("busy_timeout2", 32'd1, 32'd0); break; end
      if (c == 5) wr(1'b0, 32'h0001_6602);
      else        tick(1);
      c++;
    end
    chk("ignored_start_cycles", 32'(c), 32'd1200);
    rd_exp(1'b0, 32'h0001_6600, "ctrl_upd_busy");
    tick(5);
    chk("one_done", 32'(irq_rises - r0), 32'd1);
    chk("ign_w600", sram[600], 32'h5555_5555);
    chk("ign_w1200", sram[1200], 32'hA000_04B0);
    mem_check("ignored_mem");

    // CLEAR and SCROLL together: CLEAR wins
    wr(1'b0, 32'h0000_4103);
    wait_idle(c);
    chk("both_cycles", 32'(c), 32'd1200);
    chk("both_w0", sram[0], 32'h4141_4141);
    rd_exp(1'b0, 32'h0000_4100, "both_ctrl");
    mem_check("both_mem");

    // abort mid-scroll
    wr(1'b1, 32'h0000_0002);
    wr(1'b0, 32'h0001_0002);
    tick(99);
    wr(1'b0, 32'h0000_0004);
    rd_exp(1'b1, 32'd0, "abort_stat");
    chk("abort_cs", {31'b0, mem_chipselect}, 32'd0);
    tick(3);
    rd_exp(1'b1, 32'd0, "abort_stat_later");
    wr(1'b0, 32'h0001_3001);
    wait_idle(c);
    chk("post_abort_cycles", 32'(c), 32'd1200);
    rd_exp(1'b1, 32'd2, "post_abort_done");
    mem_check("post_abort_mem");

    // async reset mid-clear, with irq asserted beforehand
    wr(1'b0, 32'h0001_7701);
    tick(50);
    chk("pre_rst_irq", {31'b0, irq}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_cs", {31'b0, mem_chipselect}, 32'd0);
    chk("arst_irq", {31'b0, irq}, 32'd0);
    chk("arst_we", {31'b0, mem_write}, 32'd0);
    rd_exp(1'b1, 32'd0, "arst_stat");
    tick(2);
    #2;
    reset_n = 1'b1;
    tick(1);
    rd_exp(1'b0, 32'd0, "post_rst_ctrl");
    rd_exp(1'b1, 32'd0, "post_rst_stat");
    tick(1);

    // randomized commands against the model
    for (int it = 0; it < 8; it++) begin
      kind  = (it == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      fill  = 8'($urandom);
      ie    = 1'($urandom_range(0, 1));
      b1    = kind ? 1'b1 : 1'($urandom_range(0, 1));
      do_ab = (it != 0) && ($urandom_range(0, 3) == 0);
      ab_at = $urandom_range(0, 1500);
      wr(1'b0, {15'b0, ie, fill, 6'b0, b1, !kind});
      c = 0;
      while (m_left != 0 && c < 6000) begin
        rsel = $urandom_range(0, 15);
        if (do_ab && c == ab_at)  wr(1'b0, {15'b0, ie, fill, 8'h04});
        else if (rsel == 0)       wr(1'b1, 32'h0000_0002);
        else if (rsel == 1)       wr(1'b0, {15'b0, 1'($urandom_range(0, 1)), 8'($urandom), 6'b0, 2'($urandom_range(1, 3))});
        else if (rsel == 2)       begin rd_model(1'b0, "rand_ctrl"); tick(1); end
        else if (rsel == 3)       begin rd_model(1'b1, "rand_stat"); tick(1); end
        else                      tick(1);
        c++;
      end
      if (c >= 6000) chk("rand_timeout", 32'd1, 32'd0);
      tick(2);
      rd_model(1'b1, "rand_end_stat");
      rd_model(1'b0, "rand_end_ctrl");
      if (ref_valid) mem_check("rand_mem");
      tick(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
